bram_port_arbiter: RTL and testbench

Shares the single-port user BRAM between two requesters, the instruction/data cache (C) and the DMA controller (D), one access per cycle. Each requester keeps the existing memory-side handshake (read address/ack, registered read-data return, write valid), plus a write ack. The arbiter sequences BRAM accesses with owner-burst round-robin and routes returned read data back to the issuing requester by tag.

---
 rtl/bram_port_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one single-port BRAM between two requesters: the cache (c_*) and the
// DMA controller (d_*). The BRAM performs at most one access per cycle.
//
// Arbitration (default build):
//   Owner-burst round-robin. The current owner keeps the port for up to
//   MAX_GRANT consecutive grants while the other side is also requesting. When
//   the other side is idle, the owner may continue indefinitely. An owner
//   change costs no idle cycle.
//
// Optional feature, macro BRAM_ARB_DMA_PRIO_EN:
//   Strict priority for the DMA side. D is granted whenever it requests, and C
//   only when D is idle. The burst counter is held at 0 and the last-served
//   pointer is not used.
//
// Within a granted requester a pending write is served before a pending read.
// The read is acknowledged on a later grant.
//
// Read data return:
//   A RD_LATENCY-deep {valid, owner} tag pipeline follows every read grant.
//   The tag selects which requester sees r_valid. Both r_data outputs carry
//   bram_rdata unqualified.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   c_r_ready / c_r_addr   cache read request and address
//   c_r_ack                cache read accepted this cycle (combinational)
//   c_r_valid / c_r_data   cache read data return
//   c_w_valid / c_w_addr / c_w_data   cache write request
//   c_w_ack                cache write performed this cycle (combinational)
//   d_*                    same set for the DMA side
//   bram_en / bram_we / bram_addr / bram_wdata / bram_rdata   BRAM port
//
// Parameters:
//   ADDR_WIDTH  BRAM word address width
//   DATA_WIDTH  data width
//   RD_LATENCY  cycles from a read on bram_en to valid bram_rdata (1..4)
//   MAX_GRANT   burst limit per owner under contention (1..15)
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_GRANT  = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  // cache side
  input  logic                  c_r_ready,
  input  logic [ADDR_WIDTH-1:0] c_r_addr,
  output logic                  c_r_ack,
  output logic                  c_r_valid,
  output logic [DATA_WIDTH-1:0] c_r_data,
  input  logic                  c_w_valid,
  input  logic [ADDR_WIDTH-1:0] c_w_addr,
  input  logic [DATA_WIDTH-1:0] c_w_data,
  output logic                  c_w_ack,
  // DMA side
  input  logic                  d_r_ready,
  input  logic [ADDR_WIDTH-1:0] d_r_addr,
  output logic                  d_r_ack,
  output logic                  d_r_valid,
  output logic [DATA_WIDTH-1:0] d_r_data,
  input  logic                  d_w_valid,
  input  logic [ADDR_WIDTH-1:0] d_w_addr,
  input  logic [DATA_WIDTH-1:0] d_w_data,
  output logic                  d_w_ack,
  // BRAM port
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_C = 2'd1,
    ST_OWN_D = 2'd2
  } state_t;

  // Encoding of the last-served pointer and the read tag owner bit.
  localparam logic SEL_C = 1'b0;
  localparam logic SEL_D = 1'b1;

  localparam logic [3:0] MAX_GRANT_C = 4'(MAX_GRANT);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_lst;
  logic       w_lst_next;

  logic       w_req_c;
  logic       w_req_d;
  logic       w_grant_c;
  logic       w_grant_d;

  assign w_req_c = c_r_ready | c_w_valid;
  assign w_req_d = d_r_ready | d_w_valid;

  // ---------------------------------------------------------------------------
  // Grant selection and next-state computation
  // ---------------------------------------------------------------------------
  always_comb begin
    w_grant_c    = 1'b0;
    w_grant_d    = 1'b0;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_lst_next   = r_lst;
`ifdef BRAM_ARB_DMA_PRIO_EN
    w_cnt_next = 4'd0;
    if (w_req_d) begin
      w_grant_d    = 1'b1;
      w_state_next = ST_OWN_D;
    end else if (w_req_c) begin
      w_grant_c    = 1'b1;
      w_state_next = ST_OWN_C;
    end else begin
      w_state_next = ST_IDLE;
    end
`else
    unique case (r_state)
      ST_OWN_C: begin
        if (w_req_c && ((r_cnt < MAX_GRANT_C) || !w_req_d)) begin
          w_grant_c  = 1'b1;
          w_cnt_next = (r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1;
        end else if (w_req_d) begin
          // The hand-over grants the other side in this same cycle.
          w_grant_d    = 1'b1;
          w_state_next = ST_OWN_D;
          w_cnt_next   = 4'd1;
          w_lst_next   = SEL_C;
        end else begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
          w_lst_next   = SEL_C;
        end
      end
      ST_OWN_D: begin
        if (w_req_d && ((r_cnt < MAX_GRANT_C) || !w_req_c)) begin
          w_grant_d  = 1'b1;
          w_cnt_next = (r_cnt == 4'hF) ? 4'hF : r_cnt + 4'd1;
        end else if (w_req_c) begin
          w_grant_c    = 1'b1;
          w_state_next = ST_OWN_C;
          w_cnt_next   = 4'd1;
          w_lst_next   = SEL_D;
        end else begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 4'd0;
          w_lst_next   = SEL_D;
        end
      end
      default: begin
        // IDLE: on a tie, favour the side that was not served last.
        if (w_req_c && (!w_req_d || (r_lst == SEL_D))) begin
          w_grant_c    = 1'b1;
          w_state_next = ST_OWN_C;
          w_cnt_next   = 4'd1;
        end else if (w_req_d) begin
          w_grant_d    = 1'b1;
          w_state_next = ST_OWN_D;
          w_cnt_next   = 4'd1;
        end
      end
    endcase
`endif
    // No access while reset is held.
    if (wb_rst_i) begin
      w_grant_c = 1'b0;
      w_grant_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_lst   <= SEL_D;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_lst   <= w_lst_next;
    end
  end

  // ---------------------------------------------------------------------------
  // BRAM port mux and acknowledges. A write wins inside the granted side.
  // ---------------------------------------------------------------------------
  assign bram_en = w_grant_c | w_grant_d;

  always_comb begin
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (w_grant_c) begin
      if (c_w_valid) begin
        bram_we    = 1'b1;
        bram_addr  = c_w_addr;
        bram_wdata = c_w_data;
      end else begin
        bram_addr = c_r_addr;
      end
    end else if (w_grant_d) begin
      if (d_w_valid) begin
        bram_we    = 1'b1;
        bram_addr  = d_w_addr;
        bram_wdata = d_w_data;
      end else begin
        bram_addr = d_r_addr;
      end
    end
  end

  assign c_w_ack = w_grant_c & c_w_valid;
  assign c_r_ack = w_grant_c & ~c_w_valid & c_r_ready;
  assign d_w_ack = w_grant_d & d_w_valid;
  assign d_r_ack = w_grant_d & ~d_w_valid & d_r_ready;

  // ---------------------------------------------------------------------------
  // Read tag pipeline. Stage RD_LATENCY-1 lines up with bram_rdata.
  // ---------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] r_tag_vld;
  logic [RD_LATENCY-1:0] r_tag_own;
  logic [RD_LATENCY-1:0] w_tag_vld_next;
  logic [RD_LATENCY-1:0] w_tag_own_next;

  assign w_tag_vld_next[0] = bram_en & ~bram_we;
  assign w_tag_own_next[0] = w_grant_d;

  generate
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_tag
      assign w_tag_vld_next[gi] = r_tag_vld[gi-1];
      assign w_tag_own_next[gi] = r_tag_own[gi-1];
    end
  endgenerate

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_vld <= w_tag_vld_next;
      r_tag_own <= w_tag_own_next;
    end
  end

  // The valid outputs are gated by reset, so a tag that is in flight when
  // reset arrives never shows up as r_valid.
  assign c_r_valid = r_tag_vld[RD_LATENCY-1] & (r_tag_own[RD_LATENCY-1] == SEL_C) & ~wb_rst_i;
  assign d_r_valid = r_tag_vld[RD_LATENCY-1] & (r_tag_own[RD_LATENCY-1] == SEL_D) & ~wb_rst_i;
  assign c_r_data  = bram_rdata;
  assign d_r_data  = bram_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter.
// Two instances run from identical stimulus: one with RD_LATENCY=1 and one
// with RD_LATENCY=3. Each instance has its own behavioural BRAM. A read
// scoreboard per instance checks the timing, owner and data of every returned
// read.
module tb_bram_port_arbiter;

`ifdef BRAM_ARB_DMA_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        c_r_ready, c_w_valid, d_r_ready, d_w_valid;
  logic [12:0] c_r_addr, c_w_addr, d_r_addr, d_w_addr;
  logic [31:0] c_w_data, d_w_data;

  logic        c_r_ack [2];
  logic        c_r_valid [2];
  logic        c_w_ack [2];
  logic        d_r_ack [2];
  logic        d_r_valid [2];
  logic        d_w_ack [2];
  logic        bram_en [2];
  logic        bram_we [2];
  logic [31:0] c_r_data [2];
  logic [31:0] d_r_data [2];
  logic [12:0] bram_addr [2];
  logic [31:0] bram_wdata [2];
  logic [31:0] bram_rdata [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] ref_mem [0:8191];

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [31:0] mem [0:8191];
    logic [31:0] rd_pipe [LAT];

    bram_port_arbiter #(
      .ADDR_WIDTH(13), .DATA_WIDTH(32), .RD_LATENCY(LAT), .MAX_GRANT(8)
    ) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .c_r_ready(c_r_ready), .c_r_addr(c_r_addr), .c_r_ack(c_r_ack[gi]),
      .c_r_valid(c_r_valid[gi]), .c_r_data(c_r_data[gi]),
      .c_w_valid(c_w_valid), .c_w_addr(c_w_addr), .c_w_data(c_w_data),
      .c_w_ack(c_w_ack[gi]),
      .d_r_ready(d_r_ready), .d_r_addr(d_r_addr), .d_r_ack(d_r_ack[gi]),
      .d_r_valid(d_r_valid[gi]), .d_r_data(d_r_data[gi]),
      .d_w_valid(d_w_valid), .d_w_addr(d_w_addr), .d_w_data(d_w_data),
      .d_w_ack(d_w_ack[gi]),
      .bram_en(bram_en[gi]), .bram_we(bram_we[gi]), .bram_addr(bram_addr[gi]),
      .bram_wdata(bram_wdata[gi]), .bram_rdata(bram_rdata[gi])
    );

    initial begin
      for (int a = 0; a < 8192; a++) mem[a] <= pat(a);
      mem[16] <= 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
      if (bram_en[gi] && bram_we[gi]) mem[bram_addr[gi]] <= bram_wdata[gi];
      rd_pipe[0] <= mem[bram_addr[gi]];
      for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bram_rdata[gi] = rd_pipe[LAT-1];
  end

  // ---------------------------------------------------------------------------
  // Read scoreboard. Entries are pushed on each read ack and are due LAT cycles
  // later.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        own;   // 0 = cache, 1 = DMA
    logic [31:0] data;
    int          t;
  } sb_t;
  sb_t sbq [2][$];

  always @(negedge clk) begin : mon
    sb_t e;
    int  lat;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 1 : 3;
      if (rst) begin
        sbq[k].delete();
        checks++;
        if (c_r_valid[k] !== 1'b0 || d_r_valid[k] !== 1'b0) begin
          errors++;
          $display("FAIL valid_in_reset inst%0d cyc %0d: c_valid=%b d_valid=%b, want 0 0",
                   k, cyc, c_r_valid[k], d_r_valid[k]);
        end
      end else begin
        if (sbq[k].size() > 0 && sbq[k][0].t + lat == cyc) begin
          e = sbq[k].pop_front();
          checks++;
          if (c_r_valid[k] !== !e.own || d_r_valid[k] !== e.own ||
              (e.own ? d_r_data[k] : c_r_data[k]) !== e.data) begin
            errors++;
            $display("FAIL rd_return inst%0d cyc %0d: c_valid=%b d_valid=%b data=%h, want owner %0d data %h",
                     k, cyc, c_r_valid[k], d_r_valid[k],
                     e.own ? d_r_data[k] : c_r_data[k], e.own, e.data);
          end
        end else begin
          checks++;
          if (c_r_valid[k] !== 1'b0 || d_r_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL rd_spurious inst%0d cyc %0d: c_valid=%b d_valid=%b, want 0 0",
                     k, cyc, c_r_valid[k], d_r_valid[k]);
          end
        end
        if (c_r_ack[k] === 1'b1) sbq[k].push_back('{own: 1'b0, data: ref_mem[c_r_addr], t: cyc});
        if (d_r_ack[k] === 1'b1) sbq[k].push_back('{own: 1'b1, data: ref_mem[d_r_addr], t: cyc});
      end
    end
    if (!rst && c_w_ack[0] === 1'b1) ref_mem[c_w_addr] = c_w_data;
    if (!rst && d_w_ack[0] === 1'b1) ref_mem[d_w_addr] = d_w_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input int n);
    c_r_ready = 1'b0; c_w_valid = 1'b0; d_r_ready = 1'b0; d_w_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Reset holds everything quiet, then the first grant goes to the favoured side.
  task automatic test_reset();
    bit exp_c;
    rst = 1'b1;
    c_r_ready = 1'b1; c_r_addr = 13'h001;
    d_r_ready = 1'b1; d_r_addr = 13'h002;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (c_r_ack[k] !== 1'b0 || d_r_ack[k] !== 1'b0 || c_w_ack[k] !== 1'b0 ||
            d_w_ack[k] !== 1'b0 || bram_en[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_quiet inst%0d: c_ack=%b d_ack=%b en=%b, want 0 0 0",
                   k, c_r_ack[k], d_r_ack[k], bram_en[k]);
        end
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_c = !PRIO;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (c_r_ack[k] !== exp_c || d_r_ack[k] !== !exp_c) begin
        errors++;
        $display("FAIL first_grant inst%0d: c_ack=%b d_ack=%b, want %b %b",
                 k, c_r_ack[k], d_r_ack[k], exp_c, !exp_c);
      end
    end
    tick();
    if (exp_c) c_r_ready = 1'b0; else d_r_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (c_r_ack[k] !== !exp_c || d_r_ack[k] !== exp_c) begin
        errors++;
        $display("FAIL second_grant inst%0d: c_ack=%b d_ack=%b, want %b %b",
                 k, c_r_ack[k], d_r_ack[k], !exp_c, exp_c);
      end
    end
    tick();
    flush(5);
  endtask

  task automatic test_single_read();
    c_r_ready = 1'b1; c_r_addr = 13'h010;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (c_r_ack[k] !== 1'b1 || d_r_ack[k] !== 1'b0 || bram_en[k] !== 1'b1 ||
          bram_we[k] !== 1'b0 || bram_addr[k] !== 13'h010) begin
        errors++;
        $display("FAIL single_read_ack inst%0d: c_ack=%b en=%b we=%b addr=%h, want 1 1 0 010",
                 k, c_r_ack[k], bram_en[k], bram_we[k], bram_addr[k]);
      end
    end
    tick();
    c_r_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (c_r_valid[0] !== 1'b1 || c_r_data[0] !== 32'hDEAD_BEEF || d_r_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_read_data: c_valid=%b data=%h d_valid=%b, want 1 deadbeef 0",
               c_r_valid[0], c_r_data[0], d_r_valid[0]);
    end
    tick();
    flush(5);
  endtask

  // Both sides stream reads continuously. C starts one cycle early.
  task automatic test_burst();
    bit exp_c;
    int nc = 0;
    int nd = 0;
    c_r_ready = 1'b1; c_r_addr = 13'h100;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_c = PRIO ? (i == 0) : (((i / 8) % 2) == 0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (c_r_ack[k] !== exp_c || d_r_ack[k] !== !exp_c || bram_en[k] !== 1'b1) begin
          errors++;
          $display("FAIL burst_owner inst%0d grant %0d: c_ack=%b d_ack=%b en=%b, want %b %b 1",
                   k, i, c_r_ack[k], d_r_ack[k], bram_en[k], exp_c, !exp_c);
        end
      end
      tick();
      if (c_r_ack[0] === 1'b1) begin nc++; c_r_addr = 13'(13'h100 + nc); end
      if (d_r_ack[0] === 1'b1) begin nd++; d_r_addr = 13'(13'h200 + nd); end
      if (i == 0) begin d_r_ready = 1'b1; d_r_addr = 13'h200; end
    end
    flush(5);
  endtask

  task automatic test_write_then_read();
    d_w_valid = 1'b1; d_w_addr = 13'h020; d_w_data = 32'h1000_0001;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_w_ack[k] !== 1'b1 || bram_we[k] !== 1'b1 || bram_addr[k] !== 13'h020 ||
          bram_wdata[k] !== 32'h1000_0001) begin
        errors++;
        $display("FAIL dma_write inst%0d: ack=%b we=%b addr=%h wdata=%h, want 1 1 020 10000001",
                 k, d_w_ack[k], bram_we[k], bram_addr[k], bram_wdata[k]);
      end
    end
    tick();
    d_w_valid = 1'b0; c_r_ready = 1'b1; c_r_addr = 13'h020;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (c_r_ack[k] !== 1'b1) begin
        errors++;
        $display("FAIL raw_read_ack inst%0d: c_ack=%b, want 1", k, c_r_ack[k]);
      end
    end
    tick();
    c_r_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (c_r_valid[0] !== 1'b1 || c_r_data[0] !== 32'h1000_0001) begin
      errors++;
      $display("FAIL raw_data_lat1: valid=%b data=%h, want 1 10000001", c_r_valid[0], c_r_data[0]);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (c_r_valid[1] !== 1'b1 || c_r_data[1] !== 32'h1000_0001) begin
      errors++;
      $display("FAIL raw_data_lat3: valid=%b data=%h, want 1 10000001", c_r_valid[1], c_r_data[1]);
    end
    tick();
    flush(5);
  endtask

  // DMA asserts read and write together: the write goes first.
  task automatic test_dma_rw_same();
    d_r_ready = 1'b1; d_r_addr = 13'h030;
    d_w_valid = 1'b1; d_w_addr = 13'h031; d_w_data = 32'hCAFE_0031;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_w_ack[k] !== 1'b1 || d_r_ack[k] !== 1'b0) begin
        errors++;
        $display("FAIL rw_write_first inst%0d: w_ack=%b r_ack=%b, want 1 0", k, d_w_ack[k], d_r_ack[k]);
      end
    end
    tick();
    d_w_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_r_ack[k] !== 1'b1 || d_w_ack[k] !== 1'b0) begin
        errors++;
        $display("FAIL rw_read_next inst%0d: r_ack=%b w_ack=%b, want 1 0", k, d_r_ack[k], d_w_ack[k]);
      end
    end
    tick();
    d_r_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      checks++;
      if (d_r_valid[1] !== (j == 3)) begin
        errors++;
        $display("FAIL rw_lat3_valid +%0d: d_valid=%b, want %b", j, d_r_valid[1], (j == 3));
      end
    end
    checks++;
    if (d_r_data[1] !== 32'hA500_0030) begin
      errors++;
      $display("FAIL rw_lat3_data: data=%h, want a5000030", d_r_data[1]);
    end
    tick();
    flush(5);
  endtask

  // D streams reads and C joins one cycle later. C must wait for the burst limit
  // (round-robin) or until D stops requesting (DMA priority).
  task automatic test_contention();
    int sw;
    sw = PRIO ? 20 : 8;
    d_r_ready = 1'b1; d_r_addr = 13'h400;
    for (int i = 0; i <= sw; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (c_r_ack[k] !== (i == sw) || d_r_ack[k] !== (i < sw)) begin
          errors++;
          $display("FAIL contention inst%0d cycle %0d: c_ack=%b d_ack=%b, want %b %b",
                   k, i, c_r_ack[k], d_r_ack[k], (i == sw), (i < sw));
        end
      end
      tick();
      if (d_r_ack[0] === 1'b1) d_r_addr = 13'(d_r_addr + 13'd1);
      if (i == 0) begin c_r_ready = 1'b1; c_r_addr = 13'h300; end
      if (PRIO && i == sw - 1) d_r_ready = 1'b0;
    end
    flush(5);
  endtask

  // C raises a request briefly and withdraws it before being served.
  task automatic test_withdraw();
    d_r_ready = 1'b1; d_r_addr = 13'h500;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (c_r_ack[k] !== 1'b0 || d_r_ack[k] !== 1'b1 || bram_addr[k] !== 13'h500) begin
          errors++;
          $display("FAIL withdraw inst%0d cycle %0d: c_ack=%b d_ack=%b addr=%h, want 0 1 500",
                   k, i, c_r_ack[k], d_r_ack[k], bram_addr[k]);
        end
      end
      tick();
      c_r_ready = (i == 0 || i == 1); c_r_addr = 13'h0AA;
    end
    d_r_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bram_en[k] !== 1'b0 || bram_we[k] !== 1'b0 || bram_addr[k] !== 13'h000) begin
        errors++;
        $display("FAIL idle_port inst%0d: en=%b we=%b addr=%h, want 0 0 000",
                 k, bram_en[k], bram_we[k], bram_addr[k]);
      end
    end
    tick();
    flush(5);
  endtask

  // Reset lands while a read is in flight: no r_valid may follow.
  task automatic test_reset_midread();
    c_r_ready = 1'b1; c_r_addr = 13'h040;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (c_r_ack[k] !== 1'b1) begin
        errors++;
        $display("FAIL midread_ack inst%0d: c_ack=%b, want 1", k, c_r_ack[k]);
      end
    end
    tick();
    c_r_ready = 1'b0; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0; c_r_ready = 1'b1; c_r_addr = 13'h041;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (c_r_ack[k] !== 1'b1 || c_r_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset inst%0d: c_ack=%b c_valid=%b, want 1 0", k, c_r_ack[k], c_r_valid[k]);
      end
    end
    tick();
    flush(6);
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) ref_mem[a] = pat(a);
    ref_mem[16] = 32'hDEAD_BEEF;
    rst = 1'b1;
    c_r_ready = 1'b0; c_w_valid = 1'b0; d_r_ready = 1'b0; d_w_valid = 1'b0;
    c_r_addr = '0; c_w_addr = '0; d_r_addr = '0; d_w_addr = '0;
    c_w_data = '0; d_w_data = '0;

    test_reset();
    test_single_read();
    test_burst();
    test_write_then_read();
    test_dma_rw_same();
    test_contention();
    test_withdraw();
    test_reset_midread();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
